// File: rtl/rw_memory_dp.sv
// rtl/rw_memory_dp.sv - simple dual-port RAM with registered read and clear sweep
// Writes and reads are accepted only in IDLE; the CLEAR state sweeps INIT_VALUE into every word.
module rw_memory_dp #(
  parameter int          DATA_WIDTH = 8,
  parameter int          ADDR_WIDTH = 4,
  parameter int unsigned INIT_VALUE = 0,
  parameter bit          RDW_MODE   = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] W_Address,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] R_Address,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic                  Ready,
  output logic                  Drop
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] INIT_WORD = DATA_WIDTH'(INIT_VALUE);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    valid_q, valid_d;
  logic                    drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    wr_en;
  logic                    rd_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Array is deliberately unreset; the sweep is what initialises it.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (Clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    accept    = (state_q == ST_IDLE) && !Clear;
    wr_en     = WE && accept;
    rd_en     = RE && accept;
    drop_d    = (WE || RE) && !accept;
    valid_d   = rd_en;
    dout_d    = dout_q;
    mem_we    = 1'b0;
    mem_waddr = W_Address;
    mem_wdata = Data_In;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_WORD;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
    if (rd_en) begin
      if (RDW_MODE && wr_en && (W_Address == R_Address)) begin
        dout_d = Data_In;
      end else begin
        dout_d = mem_q[R_Address];
      end
    end
  end

  assign Data_Out   = dout_q;
  assign Data_Valid = valid_q;
  assign Drop       = drop_q;
  assign Ready      = (state_q == ST_IDLE);

endmodule

// File: doc/rw_memory_dp.md
Name: rw_memory_dp

Overview:
- Parametrised successor to the team's 16x8 read/write memory.
- Simple dual-port synchronous RAM: independent write port and read port in the same cycle, registered read data with a valid strobe.
- Built-in clear sequencer sweeps every location to a programmable value after reset or on request; accesses are gated by Ready.
- Used as generic scratch/config storage behind small controllers in the datapath.

Parameters:
- DATA_WIDTH, 8, width of each word.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- INIT_VALUE, 0, word written to every location by the clear sweep (truncated to DATA_WIDTH).
- RDW_MODE, 0, same-address read-during-write: 0 = read returns old data, 1 = read returns Data_In (write-through).

Ports:
- Clock  input  1  single clock, all state on posedge.
- Reset  input  1  asynchronous, active-high; restarts the clear sweep.
- Clear  input  1  synchronous request to re-run the clear sweep.
- WE  input  1  write enable.
- W_Address  input  ADDR_WIDTH  write address.
- Data_In  input  DATA_WIDTH  write data.
- RE  input  1  read enable.
- R_Address  input  ADDR_WIDTH  read address.
- Data_Out  output  DATA_WIDTH  registered read data.
- Data_Valid  output  1  high for one cycle per accepted read.
- Ready  output  1  high when accesses are accepted (state IDLE).
- Drop  output  1  one-cycle pulse when WE or RE was asserted but not accepted.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named Clock and Reset.
- Reset (async assert) sets Data_Out=0, Data_Valid=0, Drop=0, Ready=0, state=CLEAR, sweep counter=0. Array contents are not reset directly; the sweep initialises them.
- FSM has two states:
  - CLEAR: each edge writes INIT_VALUE to mem[counter] and increments counter. On the edge that writes DEPTH-1, state->IDLE and Ready=1 (registered). Sweep takes exactly DEPTH edges after Reset deasserts.
  - IDLE: Ready=1. Clear=1 at an edge -> state=CLEAR, counter=0, Ready=0 after that edge.
- Clear while in CLEAR is ignored; the sweep continues and is not restarted.
- Reset asserted mid-sweep restarts the sweep at address 0.
- Write: WE=1 && state IDLE && Clear=0 at edge -> mem[W_Address]=Data_In.
- Read: RE=1 && state IDLE && Clear=0 at edge -> Data_Out=mem[R_Address] and Data_Valid=1 after that edge. Latency is 1 cycle.
- Data_Valid=0 after any edge with no accepted read. Data_Out holds its last value when no read is accepted.
- Same-cycle read and write to different addresses: both are performed independently.
- Same-cycle read and write to the same address:
  - RDW_MODE=0: Data_Out = prior contents.
  - RDW_MODE=1: Data_Out = Data_In.
  - The memory is written in both modes.
- Clear=1 in IDLE with WE/RE in the same cycle: Clear wins. The write and read are discarded, Data_Valid=0, Drop=1.
- Drop=1 after any edge where (WE|RE)=1 and the access was not accepted (state CLEAR, or Clear in the same cycle); otherwise 0.
- Address wrap: the counter is ADDR_WIDTH+1 bits or compares against DEPTH-1; no aliasing. User addresses are full-range; there are no out-of-range cases.

Test Plan:
- Reset pulse then idle (defaults) -> Ready=0 for 16 edges, Ready=1 after the 16th; reads of addresses 0..15 all return 8'h00 with Data_Valid=1 one cycle after each RE.
- Write 8'hAA to addr 2, next cycle RE addr 2 -> Data_Out=8'hAA, Data_Valid=1 for exactly one cycle, then Data_Valid=0 and Data_Out holds 8'hAA.
- Pre-load addr 5=8'h11; same cycle WE addr 5 Data_In=8'h22 and RE addr 5 -> RDW_MODE=0 returns 8'h11, RDW_MODE=1 returns 8'h22; a following read returns 8'h22 in both modes.
- INIT_VALUE=8'h5A, after data written: pulse Clear with WE=1 in the same cycle -> write dropped, Drop=1; Ready low for 16 cycles; all locations read back 8'h5A.
- WE/RE asserted during the sweep -> Drop=1 each such cycle, Data_Valid stays 0, memory unchanged after the sweep.
- Assert Reset at sweep counter=7 -> Ready stays 0 for a full 16 edges after release; no partial Ready glitch.
